// File: rtl/apb_uart_tx_ctrl.sv
// apb_uart_tx_ctrl
//   APB3 slave that queues bytes in a TX FIFO. A small FSM hands the bytes,
//   one at a time, to a UART transmitter. It also provides status, a
//   programmable inter-byte gap, flush, overflow tracking and a drain
//   interrupt.
//
//   Register map (byte addresses, word aligned):
//     0x0 TXDATA (W)   push wdata; reads 0
//     0x4 STATUS (R)   [0] empty [1] full [2] busy [3] overflow [4] tx_active
//     0x8 CTRL   (R/W) [0] en [1] flush (W1, self-clear) [2] ovf_clr (W1) [3] ie
//     0xC GAP    (R/W) idle cycles inserted after each tx_done
//
//   Ports:
//     clock, reset            rising-edge clock, synchronous active-low reset
//     sel/enable/write/addr/wdata/rdata/ready/slverr   APB3 slave, zero wait
//     tx_dv, tx_byte          one-cycle launch strobe and held byte to UART TX
//     tx_active, tx_done      UART TX busy level (status only), done pulse
//     irq                     level interrupt: ie & empty & idle
module apb_uart_tx_ctrl #(
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              sel,
  input  logic              enable,
  input  logic              write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        wdata,
  output logic [7:0]        rdata,
  output logic              ready,
  output logic              slverr,
  output logic              tx_dv,
  output logic [7:0]        tx_byte,
  input  logic              tx_active,
  input  logic              tx_done,
  output logic              irq
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_GAP    = 2'd3;

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_DONE, GAP} state_t;

  // Decoded APB access-phase request.
  typedef struct packed {
    logic       acc;
    logic       wr;
    logic       rd;
    logic       hit;
    logic [1:0] idx;
  } apb_req_t;

  apb_req_t req;

  state_t state_q, state_d;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full, empty;

  logic       en, ie, overflow;
  logic [7:0] gap_reg;
  logic [7:0] gap_cnt;
  logic [7:0] tx_byte_q;

  logic wr_txdata, wr_ctrl, wr_gap;
  logic push, pop, flush, ovf_set, ovf_clr;
  logic busy;

  // ---------------------------------------------------------------------
  // APB decode
  // ---------------------------------------------------------------------
  always_comb begin
    req.acc = sel & enable;
    req.wr  = sel & enable & write;
    req.rd  = sel & enable & ~write;
    // Only the four word-aligned offsets 0x0..0xC are mapped.
    req.hit = (addr[1:0] == 2'b00) && ((addr >> 4) == '0);
    req.idx = addr[3:2];
  end

  assign wr_txdata = req.wr & req.hit & (req.idx == REG_TXDATA);
  assign wr_ctrl   = req.wr & req.hit & (req.idx == REG_CTRL);
  assign wr_gap    = req.wr & req.hit & (req.idx == REG_GAP);

  assign full  = (count == CNT_W'(FIFO_DEPTH));
  assign empty = (count == '0);

  // The pop in LOAD frees a slot on the same edge, so a push into a full
  // FIFO during LOAD is accepted rather than counted as an overflow.
  assign pop     = (state_q == LOAD);
  assign push    = wr_txdata & (~full | pop);
  assign ovf_set = wr_txdata & full & ~pop;
  assign flush   = wr_ctrl & wdata[1];
  assign ovf_clr = wr_ctrl & wdata[2];

  assign ready  = req.acc;
  assign slverr = (req.acc & ~req.hit) | ovf_set;

  always_comb begin
    rdata = 8'h00;
    if (req.rd && req.hit) begin
      case (req.idx)
        REG_STATUS: rdata = {3'b000, tx_active, overflow, busy, full, empty};
        REG_CTRL:   rdata = {4'b0000, ie, 2'b00, en};
        REG_GAP:    rdata = gap_reg;
        default:    rdata = 8'h00;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset) begin
      en       <= 1'b0;
      ie       <= 1'b0;
      gap_reg  <= 8'h00;
      overflow <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        en <= wdata[0];
        ie <= wdata[3];
      end
      if (wr_gap)
        gap_reg <= wdata;
      // A new overflow on the clearing edge keeps the flag set.
      if (ovf_set)
        overflow <= 1'b1;
      else if (ovf_clr)
        overflow <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // TX FIFO
  // ---------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (push)
      mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      // Flush beats a same-cycle pop; the launched byte is already on tx_byte.
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Sequencer FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      // A flush on this edge empties the FIFO, so do not commit to a LOAD
      // that would pop nothing.
      IDLE:      if (en && !empty && !flush) state_d = LOAD;
      LOAD:      state_d = WAIT_DONE;
      WAIT_DONE: if (tx_done) state_d = (gap_reg != 8'h00) ? GAP : IDLE;
      GAP:       if (gap_cnt == 8'd1) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    tx_dv = (state_q == LOAD);
    busy  = (state_q != IDLE);
    irq   = ie & empty & (state_q == IDLE);
  end

  // The gap length is captured on entry to GAP, so a GAP write made during
  // a gap only affects the next one.
  always_ff @(posedge clock) begin
    if (!reset)
      gap_cnt <= 8'h00;
    else if (state_q == WAIT_DONE && tx_done)
      gap_cnt <= gap_reg;
    else if (state_q == GAP)
      gap_cnt <= gap_cnt - 8'd1;
  end

  // The head byte is latched on the IDLE->LOAD edge, so it is valid while
  // tx_dv is high and stays put until the next launch.
  always_ff @(posedge clock) begin
    if (!reset)
      tx_byte_q <= 8'h00;
    else if (state_q == IDLE && state_d == LOAD)
      tx_byte_q <= mem[rd_ptr];
  end

  assign tx_byte = tx_byte_q;

endmodule
